// File: rtl/spi_master_pkg.sv
// Shared definitions for the parametrised SPI master: register map, CTRL and
// STATUS bit positions, and the transfer state encoding.
package spi_master_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_DIV    = 2'd1;
    localparam logic [1:0] ADDR_DATA   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_W      = 8;
    localparam int CTRL_CPOL   = 0;
    localparam int CTRL_CPHA   = 1;
    localparam int CTRL_LSB    = 2;
    localparam int CTRL_HOLD   = 3;
    localparam int CTRL_IRQ_EN = 4;
    localparam int CTRL_SS_LO  = 5;
    localparam int SS_IDX_W    = 3;

    localparam int STAT_DONE    = 0;
    localparam int STAT_OVERRUN = 1;
    localparam int STAT_BUSY    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_TRAIL = 2'd3
    } state_e;

endpackage

// File: rtl/spi_master_param_clk_gen.sv
// Half-period tick generator: emits a one-cycle tick every DIV+1 enabled cycles,
// restarting from zero whenever the enable rises.
module spi_clk_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    // Counter sits at zero while disabled, so the first tick lands DIV+1 cycles after enable.
    always_comb begin
        tick  = en && (cnt_q == div);
        cnt_d = '0;
        if (en && !tick) begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_param.sv
// Register-mapped SPI master: CTRL/DIV/DATA/STATUS registers, transfer FSM,
// shift register and slave-select decode, all clocked from pro_clk.
module spi_master_param
    import spi_master_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_SS = 8,
    parameter int DIV_W  = 8
) (
    input  logic              pro_clk,
    input  logic              rst,
    input  logic [1:0]        addr,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_SS-1:0] ss_n,
    output logic              busy,
    output logic              irq
);

    localparam int CNT_W = $clog2(2 * DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * DATA_W);

    state_e              state_q, state_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [DATA_W-1:0]   sr_q, sr_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [CNT_W-1:0]    edge_cnt_q, edge_cnt_d;
    logic                rx_bit_q, rx_bit_d;
    logic                mosi_q, mosi_d;
    logic                sclk_q, sclk_d;
    logic                ss_active_q, ss_active_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;

    logic                tick;
    logic                idle;
    logic                wr_ctrl, wr_div, wr_data, wr_status, rd_data;
    logic                cpha, lsb_first, leading, last_edge;
    logic [SS_IDX_W-1:0] ss_idx;
    logic [DATA_W-1:0]   shifted;

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v,
                                                   input logic b,
                                                   input logic lsb);
        return lsb ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
    endfunction

    function automatic logic out_bit(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DATA_W-1];
    endfunction

    spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
        .clk  (pro_clk),
        .rst  (rst),
        .en   (!idle),
        .div  (div_q),
        .tick (tick)
    );

    assign idle      = (state_q == ST_IDLE);
    assign wr_ctrl   = wr_en && (addr == ADDR_CTRL);
    assign wr_div    = wr_en && (addr == ADDR_DIV);
    assign wr_data   = wr_en && (addr == ADDR_DATA);
    assign wr_status = wr_en && (addr == ADDR_STATUS);
    assign rd_data   = rd_en && (addr == ADDR_DATA);
    assign cpha      = ctrl_q[CTRL_CPHA];
    assign lsb_first = ctrl_q[CTRL_LSB];
    assign ss_idx    = ctrl_q[CTRL_SS_LO +: SS_IDX_W];
    assign leading   = !edge_cnt_q[0];
    assign last_edge = (edge_cnt_q + CNT_W'(1)) == LAST_EDGE;

    // Register file, transfer FSM and shift datapath.
    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        div_d       = div_q;
        sr_d        = sr_q;
        rx_d        = rx_q;
        rdata_d     = rdata_q;
        edge_cnt_d  = edge_cnt_q;
        rx_bit_d    = rx_bit_q;
        mosi_d      = mosi_q;
        sclk_d      = sclk_q;
        ss_active_d = ss_active_q;
        done_d      = done_q;
        overrun_d   = overrun_q;
        shifted     = shift_in(sr_q, cpha ? miso : rx_bit_q, lsb_first);

        if (rd_data) begin
            done_d = 1'b0;
        end
        if (wr_status && wdata[STAT_OVERRUN]) begin
            overrun_d = 1'b0;
        end

        if (idle) begin
            if (wr_ctrl) begin
                ctrl_d = wdata[CTRL_W-1:0];
                if (!wdata[CTRL_HOLD] || (wdata[CTRL_SS_LO +: SS_IDX_W] != ss_idx)) begin
                    ss_active_d = 1'b0;
                end
            end
            if (wr_div) begin
                div_d = DIV_W'(wdata);
            end
            sclk_d = ctrl_d[CTRL_CPOL];
            if (wr_data) begin
                state_d     = ST_SETUP;
                sr_d        = wdata;
                edge_cnt_d  = '0;
                rx_bit_d    = 1'b0;
                ss_active_d = 1'b1;
                if (!cpha) begin
                    mosi_d = out_bit(wdata, lsb_first);
                end
            end
        end else if (wr_data) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_SETUP: begin
                if (tick) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (tick) begin
                    sclk_d     = !sclk_q;
                    edge_cnt_d = edge_cnt_q + CNT_W'(1);
                    // CPHA=0 samples on leading and shifts on trailing; CPHA=1 the reverse.
                    if (!cpha) begin
                        if (leading) begin
                            rx_bit_d = miso;
                        end else begin
                            sr_d = shifted;
                            if (!last_edge) begin
                                mosi_d = out_bit(shifted, lsb_first);
                            end
                        end
                    end else begin
                        if (leading) begin
                            mosi_d = out_bit(sr_q, lsb_first);
                        end else begin
                            sr_d = shifted;
                        end
                    end
                    if (last_edge) begin
                        state_d = ST_TRAIL;
                    end
                end
            end
            ST_TRAIL: begin
                if (tick) begin
                    state_d     = ST_IDLE;
                    rx_d        = sr_q;
                    done_d      = 1'b1;
                    ss_active_d = ctrl_q[CTRL_HOLD];
                end
            end
            default: ;
        endcase

        if (rd_en) begin
            case (addr)
                ADDR_CTRL:   rdata_d = DATA_W'(ctrl_q);
                ADDR_DIV:    rdata_d = DATA_W'(div_q);
                ADDR_DATA:   rdata_d = rx_q;
                ADDR_STATUS: rdata_d = DATA_W'({!idle, overrun_q, done_q});
                default:     rdata_d = rdata_q;
            endcase
        end
    end

    always_ff @(posedge pro_clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ctrl_q      <= '0;
            div_q       <= '0;
            sr_q        <= '0;
            rx_q        <= '0;
            rdata_q     <= '0;
            edge_cnt_q  <= '0;
            rx_bit_q    <= 1'b0;
            mosi_q      <= 1'b0;
            sclk_q      <= 1'b0;
            ss_active_q <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            div_q       <= div_d;
            sr_q        <= sr_d;
            rx_q        <= rx_d;
            rdata_q     <= rdata_d;
            edge_cnt_q  <= edge_cnt_d;
            rx_bit_q    <= rx_bit_d;
            mosi_q      <= mosi_d;
            sclk_q      <= sclk_d;
            ss_active_q <= ss_active_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

    // An out-of-range SS_IDX matches no line, so the transfer runs unselected.
    always_comb begin
        ss_n = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if (ss_active_q && (ss_idx == SS_IDX_W'(i))) begin
                ss_n[i] = 1'b0;
            end
        end
    end

    assign rdata = rdata_q;
    assign sclk  = sclk_q;
    assign mosi  = mosi_q;
    assign busy  = !idle;
    assign irq   = done_q && ctrl_q[CTRL_IRQ_EN];

endmodule

// File: tb/tb_spi_master_param.sv
// Directed self-checking bench for spi_master_param (DATA_W=8, NUM_SS=8, DIV_W=8)
// with a behavioural SPI slave and a mosi loopback option.
module tb_spi_master_param;

    localparam int DATA_W = 8;
    localparam int NUM_SS = 8;
    localparam int DIV_W  = 8;

    logic              pro_clk = 1'b0;
    logic              rst     = 1'b1;
    logic [1:0]        addr    = 2'd0;
    logic              wr_en   = 1'b0;
    logic              rd_en   = 1'b0;
    logic [DATA_W-1:0] wdata   = '0;
    logic [DATA_W-1:0] rdata;
    logic              sclk;
    logic              mosi;
    logic              miso;
    logic [NUM_SS-1:0] ss_n;
    logic              busy;
    logic              irq;

    int checks = 0;
    int errors = 0;

    logic       loopback  = 1'b1;
    logic       slave_en  = 1'b0;
    logic       tb_cpol   = 1'b0;
    logic       tb_cpha   = 1'b0;
    logic [7:0] slave_val = 8'h00;
    logic [7:0] slave_sh  = 8'h00;
    logic       slave_miso = 1'b0;
    logic       sclk_prev = 1'b0;

    logic [7:0] exp_ss   = 8'hFE;
    logic       hold_mon = 1'b0;
    int         busy_cycles = 0;
    int         ss_bad      = 0;
    int         hold_bad    = 0;
    int         sclk_rises  = 0;
    logic [7:0] mosi_cap    = 8'h00;

    spi_master_param #(.DATA_W(DATA_W), .NUM_SS(NUM_SS), .DIV_W(DIV_W)) dut (
        .pro_clk (pro_clk),
        .rst     (rst),
        .addr    (addr),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .wdata   (wdata),
        .rdata   (rdata),
        .sclk    (sclk),
        .mosi    (mosi),
        .miso    (miso),
        .ss_n    (ss_n),
        .busy    (busy),
        .irq     (irq)
    );

    always #5 pro_clk = ~pro_clk;

    assign miso = loopback ? mosi : slave_miso;

    // Free-running monitors; tests take snapshots and compare deltas.
    always @(negedge pro_clk) begin
        if (busy === 1'b1) begin
            busy_cycles++;
            if (ss_n !== exp_ss) ss_bad++;
        end
        if (hold_mon && ss_n !== 8'hFB) hold_bad++;
    end

    always @(posedge sclk) begin
        sclk_rises++;
        mosi_cap = {mosi_cap[6:0], mosi};
    end

    // Behavioural slave, MSB first on the wire, loaded when busy rises.
    always @(sclk or posedge busy) begin
        logic lead;
        if (sclk !== sclk_prev) begin
            sclk_prev = sclk;
            if (slave_en && busy === 1'b1) begin
                lead = (sclk !== tb_cpol);
                if (!tb_cpha && !lead) begin
                    slave_sh   = slave_sh << 1;
                    slave_miso = slave_sh[7];
                end else if (tb_cpha && lead) begin
                    slave_miso = slave_sh[7];
                    slave_sh   = slave_sh << 1;
                end
            end
        end else if (busy === 1'b1) begin
            slave_sh   = slave_val;
            slave_miso = tb_cpha ? 1'b0 : slave_val[7];
        end
    end

    task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge pro_clk);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        @(negedge pro_clk);
        wr_en = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge pro_clk);
        addr  = a;
        rd_en = 1'b1;
        @(negedge pro_clk);
        rd_en = 1'b0;
        d = rdata;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 2000 && busy !== 1'b0; i++) @(negedge pro_clk);
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: busy=%b after 2000 cycles, required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst = 1'b1;
        repeat (3) @(negedge pro_clk);
        checks++; if (sclk !== 1'b0)  begin errors++; $display("[TB] FAIL reset_sclk got %b want 0", sclk); end
        checks++; if (mosi !== 1'b0)  begin errors++; $display("[TB] FAIL reset_mosi got %b want 0", mosi); end
        checks++; if (ss_n !== 8'hFF) begin errors++; $display("[TB] FAIL reset_ss_n got %h want ff", ss_n); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++; if (irq !== 1'b0)   begin errors++; $display("[TB] FAIL reset_irq got %b want 0", irq); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_rdata got %h want 00", rdata); end
        rst = 1'b0;
        reg_read(2'd0, d);
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL reset_ctrl got %h want 00", d); end
        reg_read(2'd3, d);
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL reset_status got %h want 00", d); end
    endtask

    task automatic test_mode0_loopback();
        int b0, r0, s0;
        logic [7:0] d;
        reg_write(2'd0, 8'h00);
        reg_write(2'd1, 8'h00);
        loopback = 1'b1;
        exp_ss   = 8'hFE;
        b0 = busy_cycles; r0 = sclk_rises; s0 = ss_bad;
        reg_write(2'd2, 8'hA5);
        checks++; if (busy !== 1'b1 || ss_n !== 8'hFE) begin errors++; $display("[TB] FAIL m0_start busy=%b ss_n=%h want 1/fe", busy, ss_n); end
        wait_idle("m0");
        checks++; if (busy_cycles - b0 != 18) begin errors++; $display("[TB] FAIL m0_busy_len got %0d want 18", busy_cycles - b0); end
        checks++; if (sclk_rises - r0 != 8) begin errors++; $display("[TB] FAIL m0_sclk_rises got %0d want 8", sclk_rises - r0); end
        checks++; if (mosi_cap !== 8'hA5) begin errors++; $display("[TB] FAIL m0_mosi_bits got %h want a5", mosi_cap); end
        checks++; if (ss_bad != s0) begin errors++; $display("[TB] FAIL m0_ss_during got %0d bad cycles want 0", ss_bad - s0); end
        checks++; if (ss_n !== 8'hFF) begin errors++; $display("[TB] FAIL m0_ss_release got %h want ff", ss_n); end
        reg_read(2'd3, d);
        checks++; if (d !== 8'h01) begin errors++; $display("[TB] FAIL m0_status_done got %h want 01", d); end
        reg_read(2'd2, d);
        checks++; if (d !== 8'hA5) begin errors++; $display("[TB] FAIL m0_rxdata got %h want a5", d); end
        reg_read(2'd3, d);
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL m0_done_clear got %h want 00", d); end
    endtask

    task automatic test_modes();
        int b0, r0, s0;
        logic [7:0] d;
        for (int m = 1; m <= 3; m++) begin
            reg_write(2'd0, 8'(m));
            reg_write(2'd1, 8'h03);
            checks++; if (sclk !== m[0]) begin errors++; $display("[TB] FAIL mode%0d_idle_sclk got %b want %b", m, sclk, m[0]); end
            tb_cpol   = m[0];
            tb_cpha   = m[1];
            slave_val = 8'hC3;
            loopback  = 1'b0;
            slave_en  = 1'b1;
            exp_ss    = 8'hFE;
            b0 = busy_cycles; r0 = sclk_rises; s0 = ss_bad;
            reg_write(2'd2, 8'h3C);
            wait_idle("modes");
            slave_en = 1'b0;
            checks++; if (busy_cycles - b0 != 72) begin errors++; $display("[TB] FAIL mode%0d_busy_len got %0d want 72", m, busy_cycles - b0); end
            checks++; if (sclk_rises - r0 != 8) begin errors++; $display("[TB] FAIL mode%0d_sclk_rises got %0d want 8", m, sclk_rises - r0); end
            checks++; if (ss_bad != s0) begin errors++; $display("[TB] FAIL mode%0d_ss_during got %0d bad want 0", m, ss_bad - s0); end
            checks++; if (sclk !== m[0]) begin errors++; $display("[TB] FAIL mode%0d_end_sclk got %b want %b", m, sclk, m[0]); end
            reg_read(2'd2, d);
            checks++; if (d !== 8'hC3) begin errors++; $display("[TB] FAIL mode%0d_rxdata got %h want c3", m, d); end
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] d;
        reg_write(2'd0, 8'h04);
        reg_write(2'd1, 8'h00);
        tb_cpol   = 1'b0;
        tb_cpha   = 1'b0;
        slave_val = 8'h80;
        loopback  = 1'b0;
        slave_en  = 1'b1;
        reg_write(2'd2, 8'h01);
        wait_idle("lsb");
        slave_en = 1'b0;
        checks++; if (mosi_cap !== 8'h80) begin errors++; $display("[TB] FAIL lsb_mosi_bits got %h want 80", mosi_cap); end
        reg_read(2'd2, d);
        checks++; if (d !== 8'h01) begin errors++; $display("[TB] FAIL lsb_rxdata got %h want 01", d); end
    endtask

    task automatic test_overrun();
        int b0;
        logic [7:0] d;
        reg_write(2'd0, 8'h00);
        reg_write(2'd1, 8'h03);
        loopback = 1'b1;
        b0 = busy_cycles;
        reg_write(2'd2, 8'h5A);
        repeat (10) @(negedge pro_clk);
        reg_write(2'd2, 8'hFF);
        reg_write(2'd0, 8'h01);
        wait_idle("overrun");
        checks++; if (busy_cycles - b0 != 72) begin errors++; $display("[TB] FAIL ovr_busy_len got %0d want 72", busy_cycles - b0); end
        reg_read(2'd3, d);
        checks++; if (d !== 8'h03) begin errors++; $display("[TB] FAIL ovr_status got %h want 03", d); end
        reg_read(2'd2, d);
        checks++; if (d !== 8'h5A) begin errors++; $display("[TB] FAIL ovr_rxdata got %h want 5a", d); end
        reg_read(2'd0, d);
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL ovr_ctrl_locked got %h want 00", d); end
        reg_write(2'd3, 8'h02);
        reg_read(2'd3, d);
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL ovr_clear got %h want 00", d); end
    endtask

    task automatic test_back_to_back_hold();
        int h0, s0;
        logic [7:0] d;
        reg_write(2'd1, 8'h00);
        reg_write(2'd0, 8'h48);
        loopback = 1'b1;
        exp_ss   = 8'hFB;
        h0 = hold_bad; s0 = ss_bad;
        reg_write(2'd2, 8'h11);
        hold_mon = 1'b1;
        wait_idle("hold1");
        checks++; if (ss_n !== 8'hFB) begin errors++; $display("[TB] FAIL hold_idle_ss got %h want fb", ss_n); end
        reg_write(2'd2, 8'h22);
        wait_idle("hold2");
        hold_mon = 1'b0;
        checks++; if (hold_bad != h0) begin errors++; $display("[TB] FAIL hold_continuous got %0d bad want 0", hold_bad - h0); end
        checks++; if (ss_bad != s0) begin errors++; $display("[TB] FAIL hold_ss_during got %0d bad want 0", ss_bad - s0); end
        reg_read(2'd2, d);
        checks++; if (d !== 8'h22) begin errors++; $display("[TB] FAIL hold_rxdata got %h want 22", d); end
        checks++; if (ss_n !== 8'hFB) begin errors++; $display("[TB] FAIL hold_before_release got %h want fb", ss_n); end
        reg_write(2'd0, 8'h40);
        checks++; if (ss_n !== 8'hFF) begin errors++; $display("[TB] FAIL hold_release got %h want ff", ss_n); end
    endtask

    task automatic test_irq();
        logic [7:0] d;
        reg_write(2'd0, 8'h10);
        checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_idle got %b want 0", irq); end
        loopback = 1'b1;
        reg_write(2'd2, 8'h96);
        wait_idle("irq");
        checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_raise got %b want 1", irq); end
        reg_read(2'd2, d);
        checks++; if (d !== 8'h96) begin errors++; $display("[TB] FAIL irq_rxdata got %h want 96", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_fall got %b want 0", irq); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        reg_write(2'd0, 8'h03);
        reg_write(2'd1, 8'h03);
        loopback = 1'b1;
        reg_write(2'd2, 8'h77);
        repeat (12) @(negedge pro_clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_busy_before got %b want 1", busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (ss_n !== 8'hFF) begin errors++; $display("[TB] FAIL rstmid_ss_n got %h want ff", ss_n); end
        checks++; if (sclk !== 1'b0)  begin errors++; $display("[TB] FAIL rstmid_sclk got %b want 0", sclk); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("[TB] FAIL rstmid_busy got %b want 0", busy); end
        checks++; if (mosi !== 1'b0)  begin errors++; $display("[TB] FAIL rstmid_mosi got %b want 0", mosi); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_rdata got %h want 00", rdata); end
        @(negedge pro_clk);
        rst = 1'b0;
        reg_read(2'd3, d);
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_status got %h want 00", d); end
        reg_read(2'd0, d);
        checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_ctrl got %h want 00", d); end
    endtask

    initial begin
        test_reset();
        test_mode0_loopback();
        test_modes();
        test_lsb_first();
        test_overrun();
        test_back_to_back_hold();
        test_irq();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
